servo_pwm_bank: RTL
===================

Name: servo_pwm_bank

Overview:
- Multi-channel PWM generator for the biped joint servos: NCH outputs share one frame counter, each with its own high-duration.
- Double-buffered: duty and period writes go to pending registers and are applied only at the frame boundary, so no runt or glitched pulses occur.
- Sits between the gait/trajectory controller (register writes) and the servo pins.

Parameters:
- NCH, 4, number of PWM channels (1..32).
- CW, 20, counter/duty/period width in bits.
- DEFAULT_PERIOD, 999999, reset value of period (frame = period+1 cycles; 20 ms at 50 MHz).
- DEFAULT_HIGH, 75000, reset value of every channel's high-duration (1.5 ms servo centre).
- SLEW_STEP, 500, maximum change of active high-duration per frame (used only with SERVO_PWM_SLEW_EN).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run/stop for the whole bank.
- wr_en  in  1  single-cycle write strobe for a channel high-duration.
- wr_ch  in  $clog2(NCH) (min 1)  channel index for the write.
- wr_high  in  CW  new high-duration in cycles.
- per_wr  in  1  single-cycle write strobe for the period.
- per_val  in  CW  new period value (frame length minus 1).
- pwm  out  NCH  PWM outputs, bit i = channel i.
- frame_start  out  1  one-cycle pulse marking the start of each frame.

Behaviour:
- Reset (async, reset_n low):
  - tick=0, pwm=0, frame_start=0.
  - period_act=period_pend=DEFAULT_PERIOD.
  - high_act[i]=high_pend[i]=DEFAULT_HIGH.
- Counter:
  - enable low: tick held at 0.
  - Otherwise, when tick>=period_act: tick<=0. This cycle is the boundary, bnd=enable&&(tick>=period_act).
  - Otherwise tick<=tick+1.
  - tick wraps on >= rather than ==, so a period shrink below the current tick ends the frame at the next cycle.
- Outputs:
  - pwm[i] <= enable && (tick < high_act[i]), registered, 1-cycle latency from tick.
  - High time per frame is min(high_act, period_act+1) cycles.
  - high_act=0 gives constant low; high_act>period_act gives constant high.
- frame_start <= bnd; it is high in the same cycle tick reads 0.
- Writes:
  - wr_en with wr_ch<NCH loads high_pend[wr_ch]<=wr_high.
  - wr_ch>=NCH is ignored, with no side effects.
  - per_wr loads period_pend<=per_val.
  - Writes never touch active registers directly.
- Boundary update (bnd): period_act<=period_pend; high_act[i]<=high_pend[i] for all i.
  - The boundary samples pending registers as they were before any same-cycle write.
  - A write in the bnd cycle therefore takes effect at the following boundary.
- enable low: active registers track pending every cycle, so the first frame after enable rises uses the latest values. pwm=0 and frame_start=0.
- enable rising: the first frame starts at tick=0. No frame_start pulse precedes the first frame.
- enable falling mid-frame: pwm goes low on the next clock and tick clears to 0.
- All arithmetic is unsigned, CW bits; there is no overflow path because tick never exceeds max(period_act, previous tick).

Optional Feature:
- Macro: SERVO_PWM_SLEW_EN.
- Defined:
  - At each bnd, high_act[i] moves toward high_pend[i] by min(|high_pend[i]-high_act[i]|, SLEW_STEP), with no over/undershoot.
  - Limits servo step torque.
  - Period is still applied directly.
  - While enable is low, active still copies pending directly, with no slew.
- Undefined: high_act[i] loads high_pend[i] directly at bnd; SLEW_STEP is unused.

Test Plan:
- Setup for all scenarios: NCH=4, CW=16, reset, per_wr per_val=9, enable=1.
- Basic pulse:
  - Stimulus: write ch0 high=3.
  - Response: after the next boundary, pwm[0] is high 3 cycles / low 7 cycles repeating; frame_start pulses every 10 cycles.
- Double buffering:
  - Stimulus: mid-frame (tick=5) write ch1 high=7.
  - Response: the current frame keeps the old pulse; the next frame shows pwm[1] high 7 cycles.
  - Stimulus: a write in the bnd cycle.
  - Response: it appears one frame later.
- Extremes and bad index:
  - Stimulus: ch2 high=0; ch3 high=12; write wr_ch=5 (NCH=4, wr_ch width 2 truncates; bench instantiates NCH=5 and writes wr_ch=6).
  - Response: ch2 constant 0; ch3 constant 1; the out-of-range write has no effect on any channel.
- Period change:
  - Stimulus: with ch0 high=3, per_val=4 written at tick=6.
  - Response: the current frame runs to tick=9; subsequent frames are 5 cycles, pwm[0] 3 high / 2 low.
- Enable and reset:
  - Stimulus: enable low mid-pulse.
  - Response: pwm=0 the next cycle, tick=0.
  - Stimulus: reset_n low asynchronously mid-frame.
  - Response: pwm=0, frame_start=0 immediately; period is DEFAULT_PERIOD after release.
- Slew (SERVO_PWM_SLEW_EN, SLEW_STEP=2, per_val=19):
  - Stimulus: ch0 active=3, write high=8.
  - Response: successive frames show high times 5, 7, 8, 8.
  - Stimulus: write 4.
  - Response: frames show 6, 4.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
//   Multi-channel servo PWM generator. All channels share one frame counter
//   (tick); each channel drives its output high while tick is below its own
//   high-duration. Duty and period writes land in pending registers and are
//   copied to the active registers only at a frame boundary, so a frame is
//   never cut short or stretched by a mid-frame write.
//
// Ports
//   clk          clock
//   reset_n      asynchronous, active-low reset
//   enable       run/stop for the whole bank
//   wr_en        one-cycle strobe: high_pend[wr_ch] <= wr_high
//   wr_ch        channel index for wr_en (indices >= NCH are ignored)
//   wr_high      new high-duration in cycles
//   per_wr       one-cycle strobe: period_pend <= per_val
//   per_val      new period (frame length minus 1)
//   pwm          PWM outputs, bit i = channel i (registered)
//   frame_start  one-cycle pulse coinciding with tick == 0 of each frame
//
// Configuration
//   SERVO_PWM_SLEW_EN  when defined, each boundary moves a channel's active
//                      high-duration toward its pending value by at most
//                      SLEW_STEP cycles. Undefined: pending is loaded directly.

module servo_pwm_bank #(
  parameter int NCH            = 4,
  parameter int CW             = 20,
  parameter int DEFAULT_PERIOD = 999999,
  parameter int DEFAULT_HIGH   = 75000,
  parameter int SLEW_STEP      = 500
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  wr_en,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [CW-1:0]                         wr_high,
  input  logic                                  per_wr,
  input  logic [CW-1:0]                         per_val,
  output logic [NCH-1:0]                        pwm,
  output logic                                  frame_start
);

  localparam int            CHW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] PeriodRst = CW'(DEFAULT_PERIOD);
  localparam logic [CW-1:0] HighRst   = CW'(DEFAULT_HIGH);

`ifdef SERVO_PWM_SLEW_EN
  localparam logic [CW-1:0] SlewStep  = CW'(SLEW_STEP);

  // Step from cur toward tgt by at most SlewStep, landing exactly on tgt
  // when it is within reach.
  function automatic logic [CW-1:0] slewToward(input logic [CW-1:0] cur,
                                               input logic [CW-1:0] tgt);
    logic [CW-1:0] diff;
    logic [CW-1:0] res;
    if (tgt >= cur) begin
      diff = tgt - cur;
      res  = (diff > SlewStep) ? cur + SlewStep : tgt;
    end else begin
      diff = cur - tgt;
      res  = (diff > SlewStep) ? cur - SlewStep : tgt;
    end
    return res;
  endfunction
`endif

  logic [CW-1:0]  tick_q,       tick_d;
  logic [CW-1:0]  periodAct_q,  periodAct_d;
  logic [CW-1:0]  periodPend_q, periodPend_d;
  logic [CW-1:0]  highAct_q  [NCH];
  logic [CW-1:0]  highAct_d  [NCH];
  logic [CW-1:0]  highPend_q [NCH];
  logic [CW-1:0]  highPend_d [NCH];
  logic [NCH-1:0] pwm_q,        pwm_d;
  logic           frameStart_q, frameStart_d;
  logic           bnd;

  // The boundary reads only registered pending values, so a write landing in
  // the boundary cycle is deferred to the following frame. Wrapping on >=
  // lets a shrunken period end an overlong frame on the next cycle.
  always_comb begin
    bnd          = enable && (tick_q >= periodAct_q);
    tick_d       = '0;
    if (enable && !bnd) begin
      tick_d = tick_q + CW'(1);
    end
    frameStart_d = bnd;

    periodPend_d = per_wr ? per_val : periodPend_q;
    periodAct_d  = periodAct_q;
    if (!enable || bnd) begin
      periodAct_d = periodPend_q;
    end

    for (int i = 0; i < NCH; i++) begin
      highPend_d[i] = highPend_q[i];
      if (wr_en && (wr_ch == CHW'(i))) begin
        highPend_d[i] = wr_high;
      end

      highAct_d[i] = highAct_q[i];
      if (!enable) begin
        // While stopped, track pending directly so the first frame after
        // enable already uses the latest values (no slew here).
        highAct_d[i] = highPend_q[i];
      end else if (bnd) begin
`ifdef SERVO_PWM_SLEW_EN
        highAct_d[i] = slewToward(highAct_q[i], highPend_q[i]);
`else
        highAct_d[i] = highPend_q[i];
`endif
      end

      pwm_d[i] = enable && (tick_q < highAct_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q       <= '0;
      periodAct_q  <= PeriodRst;
      periodPend_q <= PeriodRst;
      pwm_q        <= '0;
      frameStart_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        highAct_q[i]  <= HighRst;
        highPend_q[i] <= HighRst;
      end
    end else begin
      tick_q       <= tick_d;
      periodAct_q  <= periodAct_d;
      periodPend_q <= periodPend_d;
      pwm_q        <= pwm_d;
      frameStart_q <= frameStart_d;
      for (int i = 0; i < NCH; i++) begin
        highAct_q[i]  <= highAct_d[i];
        highPend_q[i] <= highPend_d[i];
      end
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = frameStart_q;

endmodule
